// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the RAT program-memory loader.
// Holds the loader FSM encoding, memory geometry and the checksum accumulate step.
package prog_loader_pkg;

    localparam int         ADDR_W        = 10;
    localparam int         DATA_W        = 18;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_B0     = 3'd3,
        ST_B1     = 3'd4,
        ST_B2     = 3'd5,
        ST_CKSUM  = 3'd6
    } state_e;

    // Mod-256 running sum used for the frame checksum.
    function automatic logic [7:0] cksum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Framed UART byte stream -> 18-bit program RAM writer; holds the MCU in reset while loading.
// Optional inter-byte timeout is built only when PROG_LOADER_TIMEOUT_EN is defined.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         MAX_WORDS      = 1024
`ifdef PROG_LOADER_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              MCU_RST,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    // Wide enough to hold MAX_WORDS itself, not just MAX_WORDS-1.
    localparam int WCNT_W = $clog2(MAX_WORDS + 1);

    state_e              state_q, state_d;
    logic [7:0]          cnt_hi_q, cnt_hi_d;
    logic [WCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [WCNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          b0_q, b0_d;
    logic [7:0]          b1_q, b1_d;
    logic [7:0]          sum_q, sum_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                mcu_rst_q, mcu_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [15:0]         cnt_full_s;
    logic [WCNT_W-1:0]   wr_cnt_inc_s;
    logic                to_trip_s;

    assign cnt_full_s   = {cnt_hi_q, RX_DATA};
    assign wr_cnt_inc_s = wr_cnt_q + WCNT_W'(1);

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Inter-byte silence counter; idle or a fresh byte restarts it.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (RX_VALID || (state_q == ST_IDLE)) begin
            to_cnt_d = {TO_W{1'b0}};
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    assign to_trip_s = (state_q != ST_IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Timeout counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_cnt_q <= {TO_W{1'b0}};
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_trip_s = 1'b0;
`endif

    // Frame parser: next state, byte assembly, checksum and write generation.
    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        frame_cnt_d = frame_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        addr_d      = addr_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        sum_d       = sum_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mcu_rst_d   = mcu_rst_q;
        done_d      = 1'b0;
        err_d       = err_q;

        if (RX_VALID) begin
            case (state_q)
                ST_IDLE: begin
                    if (RX_DATA == SYNC_BYTE) begin
                        state_d   = ST_CNT_HI;
                        err_d     = 1'b0;
                        addr_d    = {ADDR_W{1'b0}};
                        wr_cnt_d  = {WCNT_W{1'b0}};
                        sum_d     = 8'h00;
                        mcu_rst_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CNT_HI: begin
                    cnt_hi_d = RX_DATA;
                    sum_d    = cksum_add(sum_q, RX_DATA);
                    state_d  = ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    sum_d       = cksum_add(sum_q, RX_DATA);
                    frame_cnt_d = cnt_full_s[WCNT_W-1:0];
                    if (cnt_full_s > 16'(MAX_WORDS)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (cnt_full_s == 16'h0000) begin
                        state_d = ST_CKSUM;
                    end else begin
                        state_d = ST_B0;
                    end
                end
                ST_B0: begin
                    b0_d    = RX_DATA[1:0];
                    sum_d   = cksum_add(sum_q, RX_DATA);
                    state_d = ST_B1;
                end
                ST_B1: begin
                    b1_d    = RX_DATA;
                    sum_d   = cksum_add(sum_q, RX_DATA);
                    state_d = ST_B2;
                end
                ST_B2: begin
                    sum_d     = cksum_add(sum_q, RX_DATA);
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = {b0_q, b1_q, RX_DATA};
                    addr_d    = addr_q + ADDR_W'(1);
                    wr_cnt_d  = wr_cnt_inc_s;
                    if (wr_cnt_inc_s == frame_cnt_q) begin
                        state_d = ST_CKSUM;
                    end else begin
                        state_d = ST_B0;
                    end
                end
                ST_CKSUM: begin
                    if (RX_DATA == sum_q) begin
                        done_d    = 1'b1;
                        mcu_rst_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (to_trip_s) begin
            // MCU stays in reset: the image in RAM is incomplete.
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_hi_q    <= 8'h00;
            frame_cnt_q <= {WCNT_W{1'b0}};
            wr_cnt_q    <= {WCNT_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            b0_q        <= 2'b00;
            b1_q        <= 8'h00;
            sum_q       <= 8'h00;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= {ADDR_W{1'b0}};
            wr_data_q   <= {DATA_W{1'b0}};
            mcu_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            frame_cnt_q <= frame_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            addr_q      <= addr_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            sum_q       <= sum_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            mcu_rst_q   <= mcu_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign WR_EN   = wr_en_q;
    assign WR_ADDR = wr_addr_q;
    assign WR_DATA = wr_data_q;
    assign MCU_RST = mcu_rst_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed, table-driven bench for prog_loader: per-byte expected outputs plus
// hand-written sequences for reset mid-load, a full 1024-word frame and the timeout.
module tb_prog_loader;

    logic        CLK;
    logic        RST;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        WR_EN;
    logic [9:0]  WR_ADDR;
    logic [17:0] WR_DATA;
    logic        MCU_RST;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    prog_loader #(
        .SYNC_BYTE(8'hA5),
        .MAX_WORDS(1024)
`ifdef PROG_LOADER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID),
        .WR_EN(WR_EN),
        .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA),
        .MCU_RST(MCU_RST),
        .BUSY(BUSY),
        .DONE(DONE),
        .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Write / done monitor, sampled mid-cycle.
    int          wr_seen = 0;
    int          done_seen = 0;
    logic [9:0]  last_addr = 10'd0;
    logic [17:0] last_data = 18'd0;
    always @(negedge CLK) begin
        if (WR_EN) begin
            wr_seen   = wr_seen + 1;
            last_addr = WR_ADDR;
            last_data = WR_DATA;
        end
        if (DONE) done_seen = done_seen + 1;
    end

    typedef struct {
        logic [7:0]  rx;
        logic        wr_en;
        logic [9:0]  addr;
        logic [17:0] data;
        logic        done;
        logic        err;
        logic        mcu;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] rx, input logic we, input logic [9:0] a,
                       input logic [17:0] d, input logic dn, input logic er,
                       input logic mc, input logic bs);
        vec_t v;
        v.rx = rx; v.wr_en = we; v.addr = a; v.data = d;
        v.done = dn; v.err = er; v.mcu = mc; v.busy = bs;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // One RX_VALID strobe; returns 1 time unit after the accepting edge.
    task automatic strobe(input logic [7:0] b);
        @(negedge CLK);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(posedge CLK);
        #1;
        RX_VALID = 1'b0;
    endtask

    int          w0, d0;
    logic [7:0]  sum;
    logic [7:0]  bb0, bb1, bb2;
    logic [9:0]  iv;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; RX_VALID = 1'b0; RX_DATA = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst wr_en", WR_EN, 0);   chk("rst addr", WR_ADDR, 0);
        chk("rst data", WR_DATA, 0);  chk("rst mcu", MCU_RST, 0);
        chk("rst busy", BUSY, 0);     chk("rst done", DONE, 0);
        chk("rst err", ERR, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Good two-word frame.
        add(8'hA5,0,0,0,0,0,1,1); add(8'h00,0,0,0,0,0,1,1); add(8'h02,0,0,0,0,0,1,1);
        add(8'h03,0,0,0,0,0,1,1); add(8'hFF,0,0,0,0,0,1,1);
        add(8'hFF,1,0,18'h3FFFF,0,0,1,1);
        add(8'h01,0,0,18'h3FFFF,0,0,1,1); add(8'h23,0,0,18'h3FFFF,0,0,1,1);
        add(8'h45,1,1,18'h12345,0,0,1,1);
        add(8'h6C,0,1,18'h12345,1,0,0,0);
        // Same frame, bad checksum.
        add(8'hA5,0,1,18'h12345,0,0,1,1); add(8'h00,0,1,18'h12345,0,0,1,1);
        add(8'h02,0,1,18'h12345,0,0,1,1); add(8'h03,0,1,18'h12345,0,0,1,1);
        add(8'hFF,0,1,18'h12345,0,0,1,1);
        add(8'hFF,1,0,18'h3FFFF,0,0,1,1);
        add(8'h01,0,0,18'h3FFFF,0,0,1,1); add(8'h23,0,0,18'h3FFFF,0,0,1,1);
        add(8'h45,1,1,18'h12345,0,0,1,1);
        add(8'h6D,0,1,18'h12345,0,1,1,0);
        // Resend good frame: ERR clears on sync.
        add(8'hA5,0,1,18'h12345,0,0,1,1); add(8'h00,0,1,18'h12345,0,0,1,1);
        add(8'h02,0,1,18'h12345,0,0,1,1); add(8'h03,0,1,18'h12345,0,0,1,1);
        add(8'hFF,0,1,18'h12345,0,0,1,1);
        add(8'hFF,1,0,18'h3FFFF,0,0,1,1);
        add(8'h01,0,0,18'h3FFFF,0,0,1,1); add(8'h23,0,0,18'h3FFFF,0,0,1,1);
        add(8'h45,1,1,18'h12345,0,0,1,1);
        add(8'h6C,0,1,18'h12345,1,0,0,0);
        // Junk then empty frame.
        add(8'h7E,0,1,18'h12345,0,0,0,0); add(8'h11,0,1,18'h12345,0,0,0,0);
        add(8'hA5,0,1,18'h12345,0,0,1,1); add(8'h00,0,1,18'h12345,0,0,1,1);
        add(8'h00,0,1,18'h12345,0,0,1,1);
        add(8'h00,0,1,18'h12345,1,0,0,0);
        // Count 1025 rejected.
        add(8'hA5,0,1,18'h12345,0,0,1,1); add(8'h04,0,1,18'h12345,0,0,1,1);
        add(8'h01,0,1,18'h12345,0,1,1,0);
        // Sync byte value inside a frame is data.
        add(8'hA5,0,1,18'h12345,0,0,1,1); add(8'h00,0,1,18'h12345,0,0,1,1);
        add(8'h01,0,1,18'h12345,0,0,1,1); add(8'hA5,0,1,18'h12345,0,0,1,1);
        add(8'hA5,0,1,18'h12345,0,0,1,1);
        add(8'hA5,1,0,18'h1A5A5,0,0,1,1);
        add(8'hF0,0,0,18'h1A5A5,1,0,0,0);
        // Empty frame with wrong checksum.
        add(8'hA5,0,0,18'h1A5A5,0,0,1,1); add(8'h00,0,0,18'h1A5A5,0,0,1,1);
        add(8'h00,0,0,18'h1A5A5,0,0,1,1);
        add(8'h02,0,0,18'h1A5A5,0,1,1,0);

        for (int i = 0; i < vecs.size(); i++) begin
            strobe(vecs[i].rx);
            chk($sformatf("v%0d wr_en", i), WR_EN, vecs[i].wr_en);
            chk($sformatf("v%0d addr", i), WR_ADDR, vecs[i].addr);
            chk($sformatf("v%0d data", i), WR_DATA, vecs[i].data);
            chk($sformatf("v%0d done", i), DONE, vecs[i].done);
            chk($sformatf("v%0d err", i), ERR, vecs[i].err);
            chk($sformatf("v%0d mcu", i), MCU_RST, vecs[i].mcu);
            chk($sformatf("v%0d busy", i), BUSY, vecs[i].busy);
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d wr_en pulse", i), WR_EN, 0);
            chk($sformatf("v%0d done pulse", i), DONE, 0);
            chk($sformatf("v%0d addr hold", i), WR_ADDR, vecs[i].addr);
            chk($sformatf("v%0d data hold", i), WR_DATA, vecs[i].data);
            chk($sformatf("v%0d err hold", i), ERR, vecs[i].err);
            chk($sformatf("v%0d mcu hold", i), MCU_RST, vecs[i].mcu);
        end

        // Reset asserted after B1 of word 0.
        strobe(8'hA5); strobe(8'h00); strobe(8'h01); strobe(8'h03); strobe(8'hFF);
        chk("midrst pre mcu", MCU_RST, 1);
        chk("midrst pre busy", BUSY, 1);
        #2;
        RST = 1'b1;
        #1;
        chk("midrst wr_en", WR_EN, 0);  chk("midrst addr", WR_ADDR, 0);
        chk("midrst data", WR_DATA, 0); chk("midrst mcu", MCU_RST, 0);
        chk("midrst busy", BUSY, 0);    chk("midrst done", DONE, 0);
        chk("midrst err", ERR, 0);
        @(negedge CLK);
        RST = 1'b0;
        w0 = wr_seen; d0 = done_seen;
        strobe(8'hA5); strobe(8'h00); strobe(8'h01); strobe(8'h03);
        strobe(8'hFF); strobe(8'hFF); strobe(8'h02);
        @(posedge CLK); #1;
        chk("reload writes", wr_seen - w0, 1);
        chk("reload addr", last_addr, 0);
        chk("reload data", last_data, 18'h3FFFF);
        chk("reload done", done_seen - d0, 1);
        chk("reload err", ERR, 0);
        chk("reload mcu", MCU_RST, 0);

        // Full-depth frame, back-to-back strobes.
        w0 = wr_seen; d0 = done_seen;
        sum = 8'h04;
        strobe(8'hA5); strobe(8'h04); strobe(8'h00);
        for (int i = 0; i < 1024; i++) begin
            iv  = i[9:0];
            bb0 = {6'b111111, iv[9:8]};
            bb1 = iv[7:0];
            bb2 = ~iv[7:0];
            sum = sum + bb0 + bb1 + bb2;
            strobe(bb0); strobe(bb1); strobe(bb2);
        end
        chk("full busy before cksum", BUSY, 1);
        strobe(sum);
        @(posedge CLK); #1;
        chk("full writes", wr_seen - w0, 1024);
        chk("full last addr", last_addr, 10'd1023);
        chk("full last data", last_data, 18'h3FF00);
        chk("full done", done_seen - d0, 1);
        chk("full err", ERR, 0);
        chk("full mcu", MCU_RST, 0);
        chk("full busy", BUSY, 0);

`ifdef PROG_LOADER_TIMEOUT_EN
        strobe(8'hA5); strobe(8'h00); strobe(8'h01); strobe(8'h03);
        repeat (99) begin
            @(posedge CLK); #1;
        end
        chk("to early err", ERR, 0);
        chk("to early busy", BUSY, 1);
        @(posedge CLK); #1;
        chk("to err", ERR, 1);
        chk("to busy", BUSY, 0);
        chk("to mcu", MCU_RST, 1);
`else
        strobe(8'hA5); strobe(8'h00); strobe(8'h01); strobe(8'h03);
        repeat (200) begin
            @(posedge CLK); #1;
        end
        chk("wait err", ERR, 0);
        chk("wait busy", BUSY, 1);
        chk("wait mcu", MCU_RST, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
